ip_decode8: RTL

Byte-serial IPv4 header decoder for the 8-bit UDP core receive path. It sits between the Ethernet frame decoder and the UDP decoder. It consumes the 20-byte IPv4 header (no options), extracts length, protocol and addresses, and verifies version/IHL and the header checksum. It then forwards exactly `packet_length − 20` payload bytes downstream, or discards them when the header is bad.

---
 rtl/ip_decode8.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ip_decode8.sv
// Byte-serial IPv4 header decoder: parses a 20-byte header, validates it, then forwards or drops the payload.
// Define IP_DECODE_CHECKSUM_EN to build the header checksum accumulator and include it in the validity check.
module ip_decode8 #(
    parameter int AVL_SIZE  = 8,
    parameter int BYTE_SIZE = 8,
    parameter int IP_SIZE   = 32,
    parameter int HDR_BYTES = 20
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 start,
    input  logic                 run,
    input  logic [AVL_SIZE-1:0]  data_in,
    output logic [15:0]          packet_length,
    output logic [BYTE_SIZE-1:0] protocol,
    output logic [IP_SIZE-1:0]   src_ip,
    output logic [IP_SIZE-1:0]   dst_ip,
    output logic                 header_done,
    output logic                 header_ok,
    output logic [AVL_SIZE-1:0]  data_out,
    output logic                 data_valid,
    output logic                 data_last
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] DROP    = 2'd3;

    localparam logic [15:0] HDR_LEN  = 16'(HDR_BYTES);
    localparam logic [4:0]  LAST_IDX = 5'(HDR_BYTES - 1);

    logic [1:0]          state;
    logic [4:0]          byte_cnt;
    logic [BYTE_SIZE-1:0] byte0;
    logic [15:0]         remaining;

    logic        restart;
    logic        ver_ok;
    logic        len_ok;
    logic        csum_ok;
    logic        hdr_ok;
    logic [15:0] payload_len;

    assign restart     = start & run;
    assign ver_ok      = (byte0 == 8'h45);
    assign len_ok      = (packet_length >= HDR_LEN);
    assign hdr_ok      = ver_ok & len_ok & csum_ok;
    assign payload_len = packet_length - HDR_LEN;

`ifdef IP_DECODE_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] sum;
    logic [16:0] f1;
    logic [15:0] fold;

    // Byte 18 is already in acc as a high half, so only the last low half is added here.
    assign sum     = acc + 32'(data_in);
    assign f1      = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    assign fold    = f1[15:0] + {15'd0, f1[16]};
    assign csum_ok = (fold == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            acc <= '0;
        end else if (restart) begin
            acc <= {16'd0, data_in, 8'd0};
        end else if (run && state == HEADER) begin
            if (byte_cnt[0])
                acc <= acc + 32'(data_in);
            else
                acc <= acc + {16'd0, data_in, 8'd0};
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            byte0         <= '0;
            remaining     <= '0;
            packet_length <= '0;
            protocol      <= '0;
            src_ip        <= '0;
            dst_ip        <= '0;
            header_done   <= 1'b0;
            header_ok     <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            data_last     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low so they last exactly one cycle per event.
            header_done <= 1'b0;
            data_valid  <= 1'b0;
            data_last   <= 1'b0;

            if (restart) begin
                state     <= HEADER;
                byte_cnt  <= 5'd1;
                byte0     <= data_in;
                header_ok <= 1'b0;
            end else if (run) begin
                case (state)
                    HEADER: begin
                        byte_cnt <= byte_cnt + 5'd1;
                        case (byte_cnt)
                            5'd2:  packet_length[15:8] <= data_in;
                            5'd3:  packet_length[7:0]  <= data_in;
                            5'd9:  protocol            <= data_in;
                            5'd12: src_ip[31:24]       <= data_in;
                            5'd13: src_ip[23:16]       <= data_in;
                            5'd14: src_ip[15:8]        <= data_in;
                            5'd15: src_ip[7:0]         <= data_in;
                            5'd16: dst_ip[31:24]       <= data_in;
                            5'd17: dst_ip[23:16]       <= data_in;
                            5'd18: dst_ip[15:8]        <= data_in;
                            5'd19: dst_ip[7:0]         <= data_in;
                            default: ;
                        endcase
                        if (byte_cnt == LAST_IDX) begin
                            header_done <= 1'b1;
                            header_ok   <= hdr_ok;
                            if (len_ok && packet_length != HDR_LEN) begin
                                state     <= hdr_ok ? PAYLOAD : DROP;
                                remaining <= payload_len;
                            end else begin
                                state     <= IDLE;
                                remaining <= '0;
                            end
                        end
                    end
                    PAYLOAD: begin
                        data_out   <= data_in;
                        data_valid <= 1'b1;
                        data_last  <= (remaining == 16'd1);
                        remaining  <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= IDLE;
                    end
                    DROP: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
